// File: rtl/grp_wrr_scheduler_pkg.sv
// Shared constants and the group weighted round-robin pick rule for grp_wrr_scheduler.
package grp_sched_pkg;

  localparam logic GRP_LS = 1'b0;
  localparam logic GRP_BS = 1'b1;

  localparam int DEF_WGT_WIDTH = 4;
  localparam int DEF_LS_WEIGHT = 4;
  localparam int DEF_BS_WEIGHT = 1;

  // Returns {grant, group}. The current group keeps the turn while it has credit,
  // or when the other group has nothing to send.
  function automatic logic [1:0] wrr_pick(input logic cur, input logic credit_zero,
                                          input logic ls_req, input logic bs_req);
    logic cur_req, oth_req;
    cur_req = cur ? bs_req : ls_req;
    oth_req = cur ? ls_req : bs_req;
    if (cur_req && (!credit_zero || !oth_req)) return {1'b1, cur};
    else if (oth_req)                          return {1'b1, ~cur};
    else                                       return {1'b0, cur};
  endfunction

endpackage

// File: rtl/grp_wrr_scheduler_if.sv
// WQE delivery handshake between grp_wrr_scheduler (master) and ib_transport (slave).
interface grp_wrr_scheduler_if #(
  parameter int WQE_WIDTH = 512,
  parameter int SLOT_AW   = 3
);
  logic                 i_wqe_cache_rd;
  logic                 o_wqe_cache_empty;
  logic                 o_wqe_val;
  logic                 o_wqe_type;
  logic [SLOT_AW-1:0]   o_wqe_addr;
  logic [WQE_WIDTH-1:0] o_wqe;

  modport master (input i_wqe_cache_rd,
                  output o_wqe_cache_empty, o_wqe_val, o_wqe_type, o_wqe_addr, o_wqe);
  modport slave  (output i_wqe_cache_rd,
                  input o_wqe_cache_empty, o_wqe_val, o_wqe_type, o_wqe_addr, o_wqe);
endinterface

// File: rtl/grp_wrr_scheduler_rr_n_ptr.sv
// Rotating-priority round-robin: first set request at or above ptr, wrapping at N-1.
module rr_n_ptr #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  input  logic          ena,
  output logic [N-1:0]  onehot,
  output logic [AW-1:0] index,
  output logic          valid
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [AW-1:0]  off;

  // Rotate so ptr sits at bit 0; lowest set bit of rot is the winner.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) off = AW'(i);
  end

  // N is a power of two, so the add wraps naturally.
  assign index  = off + ptr;
  assign valid  = ena & (|req);
  assign onehot = valid ? (N'(1) << index) : '0;
endmodule

// File: rtl/grp_wrr_scheduler.sv
// Two-group (LS/BS) WRR WQE scheduler with per-slot RR, write-back collision deferral,
// and a latched pending request. Optional grant/collision counters: GRP_SCHED_STATS_EN.
module grp_wrr_scheduler
  import grp_sched_pkg::*;
#(
  parameter int WQE_WIDTH = 512,
  parameter int SLOT_NUM  = 8,
  parameter int WGT_WIDTH = DEF_WGT_WIDTH,
  parameter int LS_WEIGHT = DEF_LS_WEIGHT,
  parameter int BS_WEIGHT = DEF_BS_WEIGHT,
  localparam int SLOT_AW  = $clog2(SLOT_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ls_empty,
  output logic                 o_ls_ren,
  input  logic [WQE_WIDTH-1:0] i_ls_rdata,
  output logic                 o_buf_ren,
  output logic                 o_buf_wen,
  output logic [SLOT_AW-1:0]   o_buf_addr,
  output logic [WQE_WIDTH-1:0] o_buf_din,
  input  logic [WQE_WIDTH-1:0] i_buf_dout,
  input  logic [SLOT_NUM-1:0]  i_slot_status,
  input  logic                 i_pwqe_wb,
  input  logic [SLOT_AW-1:0]   i_pwqe_addr,
  input  logic [WQE_WIDTH-1:0] i_pwqe,
  grp_wrr_scheduler_if.master  wqe_if
`ifdef GRP_SCHED_STATS_EN
  ,
  output logic [31:0]          o_ls_grant_cnt,
  output logic [31:0]          o_bs_grant_cnt,
  output logic [15:0]          o_collision_cnt
`endif
);
  localparam logic [WGT_WIDTH-1:0] LS_W = WGT_WIDTH'(LS_WEIGHT);
  localparam logic [WGT_WIDTH-1:0] BS_W = WGT_WIDTH'(BS_WEIGHT);

  logic                 pend_r, req, ls_req, bs_req;
  logic                 cur_grp;
  logic [WGT_WIDTH-1:0] credit;
  logic [SLOT_AW-1:0]   slot_ptr, slot_idx;
  logic [SLOT_NUM-1:0]  slot_oh;
  logic                 slot_vld;
  logic [1:0]           pick_full, pick;
  logic                 collision, grant, grp, ls_grant, bs_grant;
  logic [2:1]           vld_pipe;
  logic                 wqe_type_q, val_type;
  logic [SLOT_AW-1:0]   wqe_addr_q;

  assign req    = wqe_if.i_wqe_cache_rd | pend_r;
  assign ls_req = req & ~i_ls_empty;

  rr_n_ptr #(.N(SLOT_NUM), .AW(SLOT_AW)) u_slot_rr (
    .req    (i_slot_status),
    .ptr    (slot_ptr),
    .ena    (req),
    .onehot (slot_oh),
    .index  (slot_idx),
    .valid  (slot_vld)
  );
  assign bs_req = slot_vld & (|slot_oh);

  // A write-back owns the shared buffer port; re-pick as if BS were idle.
  assign pick_full = wrr_pick(cur_grp, credit == '0, ls_req, bs_req);
  assign collision = pick_full[1] & (pick_full[0] == GRP_BS) & i_pwqe_wb;
  assign pick      = wrr_pick(cur_grp, credit == '0, ls_req, bs_req & ~i_pwqe_wb);
  assign grant     = pick[1];
  assign grp       = pick[0];
  assign ls_grant  = grant & (grp == GRP_LS);
  assign bs_grant  = grant & (grp == GRP_BS);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r     <= 1'b0;
      cur_grp    <= GRP_LS;
      credit     <= LS_W;
      slot_ptr   <= '0;
      o_ls_ren   <= 1'b0;
      o_buf_ren  <= 1'b0;
      o_buf_wen  <= 1'b0;
      o_buf_addr <= '0;
      o_buf_din  <= '0;
      wqe_type_q <= 1'b0;
      wqe_addr_q <= '0;
      val_type   <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      pend_r <= req & ~grant;
      if (grant) begin
        if (grp == cur_grp) begin
          credit <= (credit == '0) ? '0 : credit - 1'b1;
        end else begin
          cur_grp <= grp;
          credit  <= ((grp == GRP_BS) ? BS_W : LS_W) - 1'b1;
        end
        wqe_type_q <= grp;
        wqe_addr_q <= bs_grant ? slot_idx : '0;
      end
      if (bs_grant) slot_ptr <= slot_idx + 1'b1;

      o_ls_ren  <= ls_grant;
      o_buf_ren <= bs_grant;
      o_buf_wen <= i_pwqe_wb;
      if (i_pwqe_wb) begin
        o_buf_addr <= i_pwqe_addr;
        o_buf_din  <= i_pwqe;
      end else if (bs_grant) begin
        o_buf_addr <= slot_idx;
      end

      vld_pipe <= {vld_pipe[1], grant};
      if (vld_pipe[1]) val_type <= wqe_type_q;
    end
  end

  // Read data arrives one cycle after the strobe, so the output mux is combinational.
  assign wqe_if.o_wqe_val         = vld_pipe[2];
  assign wqe_if.o_wqe_type        = wqe_type_q;
  assign wqe_if.o_wqe_addr        = wqe_addr_q;
  assign wqe_if.o_wqe             = !vld_pipe[2] ? '0 : (val_type ? i_buf_dout : i_ls_rdata);
  assign wqe_if.o_wqe_cache_empty = i_ls_empty & ~(|i_slot_status);

`ifdef GRP_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ls_grant_cnt  <= '0;
      o_bs_grant_cnt  <= '0;
      o_collision_cnt <= '0;
    end else begin
      if (ls_grant  && o_ls_grant_cnt  != '1) o_ls_grant_cnt  <= o_ls_grant_cnt + 1'b1;
      if (bs_grant  && o_bs_grant_cnt  != '1) o_bs_grant_cnt  <= o_bs_grant_cnt + 1'b1;
      if (collision && o_collision_cnt != '1) o_collision_cnt <= o_collision_cnt + 1'b1;
    end
  end
`else
  logic unused_collision;
  assign unused_collision = collision;
`endif
endmodule
